// File: rtl/totient_counter.sv
// Sequential Euler-totient engine: sweeps (n, k) for k = 1..n through an external
// combinational coprime checker and counts the coprime pairs into phi(n).
module totient_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] phi,
   output logic [WIDTH-1:0] num1,
   output logic [WIDTH-1:0] num2,
   input  logic             coprime
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] k_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] n_nx;
   logic [WIDTH-1:0] k_nx;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] acc_inc;
   logic [WIDTH-1:0] phi_nx;
   logic [WIDTH-1:0] num1_nx;
   logic [WIDTH-1:0] num2_nx;
   logic             busy_nx;
   logic             done_nx;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_nx = state;
      n_nx     = n_q;
      k_nx     = k_q;
      acc_nx   = acc_q;
      phi_nx   = phi;
      acc_inc  = acc_q + {{(WIDTH-1){1'b0}}, coprime};
      case (state)
         IDLE: begin
            if (start) begin
               if (n != ZERO) begin
                  n_nx     = n;
                  k_nx     = ONE;
                  acc_nx   = ZERO;
                  state_nx = SWEEP;
               end else begin
                  acc_nx   = ZERO;
                  phi_nx   = ZERO;
                  state_nx = DONE;
               end
            end else begin
               state_nx = IDLE;
            end
         end
         SWEEP: begin
            acc_nx = acc_inc;
            // Stopping on k == n keeps k from ever wrapping, even at n = 2^WIDTH-1.
            if (k_q == n_q) begin
               phi_nx   = acc_inc;
               state_nx = DONE;
            end else begin
               k_nx = k_q + ONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      busy_nx = (state_nx != IDLE);
      done_nx = (state_nx == DONE);
      num1_nx = (state_nx == SWEEP) ? n_nx : ZERO;
      num2_nx = (state_nx == SWEEP) ? k_nx : ZERO;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q   <= ZERO;
         k_q   <= ZERO;
         acc_q <= ZERO;
         phi   <= ZERO;
         num1  <= ZERO;
         num2  <= ZERO;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         n_q   <= n_nx;
         k_q   <= k_nx;
         acc_q <= acc_nx;
         phi   <= phi_nx;
         num1  <= num1_nx;
         num2  <= num2_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

endmodule

// File: tb/tb_totient_counter.sv
// Directed + randomized bench for totient_counter with a gcd-based checker model
// and a factorization-based phi reference.
module tb_totient_counter;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] n_in;
   logic        busy;
   logic        done;
   logic [31:0] phi;
   logic [31:0] num1;
   logic [31:0] num2;
   logic        coprime;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_cyc = 0;
   int          done_cyc_prev = 0;
   logic [31:0] prev_phi = 32'd0;

   totient_counter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n_in),
      .busy(busy), .done(done), .phi(phi),
      .num1(num1), .num2(num2), .coprime(coprime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] gcd(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] t;
      a = a_in;
      b = b_in;
      while (b != 32'd0) begin
         t = b;
         b = a % b;
         a = t;
      end
      return a;
   endfunction

   // Behavioural coprime checker sitting between num1/num2 and coprime
   always_comb coprime = (gcd(num1, num2) == 32'd1);

   // phi(n) = n * prod(1 - 1/p) over distinct primes p dividing n
   function automatic logic [31:0] phi_ref(input logic [31:0] nv);
      logic [31:0] r;
      logic [31:0] m;
      if (nv == 32'd0) return 32'd0;
      r = nv;
      m = nv;
      for (logic [31:0] p = 32'd2; p * p <= m; p++) begin
         if (m % p == 32'd0) begin
            while (m % p == 32'd0) m = m / p;
            r = r - r / p;
         end
      end
      if (m > 32'd1) r = r - r / m;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Starts a run at the current negedge (DUT in IDLE) and checks every cycle until
   // the idle cycle after done; returns at that idle negedge.
   task automatic run(input logic [31:0] nv, input logic [31:0] exp_phi,
                      input bit hold, input int pulse_at);
      start = 1'b1;
      n_in  = nv;
      @(negedge clk);
      if (!hold) start = 1'b0;
      for (int i = 1; i <= int'(nv); i++) begin
         chk("sweep_busy", {31'd0, busy}, 32'd1);
         chk("sweep_done", {31'd0, done}, 32'd0);
         chk("sweep_num1", num1, nv);
         chk("sweep_num2", num2, i);
         chk("sweep_phi_hold", phi, prev_phi);
         if (i == pulse_at) begin
            start = 1'b1;
            n_in  = 32'd7;
         end else if (!hold) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_phi", phi, exp_phi);
      chk("done_num1", num1, 32'd0);
      chk("done_num2", num2, 32'd0);
      done_cyc_prev = done_cyc;
      done_cyc      = cyc;
      prev_phi      = exp_phi;
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_phi", phi, exp_phi);
   endtask

   initial begin
      logic [31:0] nv;
      rst   = 1'b1;
      start = 1'b0;
      n_in  = 32'd0;
      #3;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_phi", phi, 32'd0);
      chk("reset_num1", num1, 32'd0);
      chk("reset_num2", num2, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run(32'd1, 32'd1, 1'b0, 0);
      run(32'd10, 32'd4, 1'b0, 0);
      run(32'd13, 32'd12, 1'b0, 0);
      run(32'd0, 32'd0, 1'b0, 0);
      run(32'd12, 32'd4, 1'b0, 5);

      // Asynchronous reset in the middle of a sweep of n = 30
      start = 1'b1;
      n_in  = 32'd30;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_done", {31'd0, done}, 32'd0);
      chk("async_phi", phi, 32'd0);
      chk("async_num1", num1, 32'd0);
      chk("async_num2", num2, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_phi = 32'd0;
      @(negedge clk);
      run(32'd30, 32'd8, 1'b0, 0);

      // start held high: runs repeat back to back
      run(32'd6, 32'd2, 1'b1, 0);
      run(32'd6, 32'd2, 1'b1, 0);
      chk("hold_spacing", done_cyc - done_cyc_prev, 32'd8);
      run(32'd6, 32'd2, 1'b1, 0);
      chk("hold_spacing2", done_cyc - done_cyc_prev, 32'd8);
      start = 1'b0;
      @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         nv = 32'($urandom_range(60, 1));
         run(nv, phi_ref(nv), 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
